// File: rtl/div_iter_pkg.sv
// Shared types for the iterative divider: FSM state encoding.
package div_iter_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ZERO = 2'd1,
        DIV_RUN  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (DIV/DIVU) for the EX stage.
// Produces {remainder, quotient} after WIDTH+1 cycles; annul abandons an op in flight.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               annul,
    output logic               busy,
    output logic               ready,
    output logic               div_zero,
    output logic [2*WIDTH-1:0] result
);

    div_state_t        state;
    logic [CNTW-1:0]   cnt;
    logic [WIDTH-1:0]  rem;
    logic [WIDTH-1:0]  dvd;
    logic [WIDTH:0]    dsr;
    logic              neg_q;
    logic              neg_r;
    logic              dz;

    logic [WIDTH-1:0]  mag1;
    logic [WIDTH-1:0]  mag2;
    logic [WIDTH:0]    shifted;
    logic              fits;
    logic [WIDTH-1:0]  q_fix;
    logic [WIDTH-1:0]  r_fix;

    // Magnitudes are taken from the live operands; they are only used on an accepted start.
    assign mag1    = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
    assign mag2    = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
    assign shifted = {rem, dvd[WIDTH-1]};
    assign fits    = (shifted >= dsr);
    assign q_fix   = neg_q ? -dvd : dvd;
    assign r_fix   = neg_r ? -rem : rem;

    assign busy = (state != DIV_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= DIV_IDLE;
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            dsr      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            ready    <= 1'b0;
            div_zero <= 1'b0;
            result   <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads pre-edge values.
            ready <= 1'b0;
            if (annul) begin
                state <= DIV_IDLE;
            end else begin
                case (state)
                    DIV_IDLE: begin
                        if (start) begin
                            neg_q <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                            neg_r <= signed_div & opdata1[WIDTH-1];
                            dvd   <= mag1;
                            dsr   <= {1'b0, mag2};
                            rem   <= '0;
                            cnt   <= '0;
                            dz    <= (opdata2 == '0);
                            state <= (opdata2 == '0) ? DIV_ZERO : DIV_RUN;
                        end
                    end
                    DIV_ZERO: begin
                        // Zeroed here rather than on result, so an annul still leaves result intact.
                        rem   <= '0;
                        dvd   <= '0;
                        state <= DIV_DONE;
                    end
                    DIV_RUN: begin
                        if (fits) begin
                            rem <= WIDTH'(shifted - dsr);
                            dvd <= {dvd[WIDTH-2:0], 1'b1};
                        end else begin
                            rem <= shifted[WIDTH-1:0];
                            dvd <= {dvd[WIDTH-2:0], 1'b0};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == CNTW'(WIDTH - 1)) begin
                            state <= DIV_DONE;
                        end
                    end
                    DIV_DONE: begin
                        result   <= {r_fix, q_fix};
                        div_zero <= dz;
                        ready    <= 1'b1;
                        state    <= DIV_IDLE;
                    end
                    default: state <= DIV_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter (WIDTH=32): latency, sign rules, div-by-zero, annul, reset.
module tb_div_iter;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           start = 1'b0;
    logic           signed_div = 1'b0;
    logic           annul = 1'b0;
    logic [W-1:0]   opdata1 = '0;
    logic [W-1:0]   opdata2 = '0;
    logic           busy;
    logic           ready;
    logic           div_zero;
    logic [2*W-1:0] result;

    int total = 0;
    int bad   = 0;
    int lat;
    int bcnt;
    int seen;

    always #5 clk = ~clk;

    div_iter #(.WIDTH(W), .CNTW(6)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .busy       (busy),
        .ready      (ready),
        .div_zero   (div_zero),
        .result     (result)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // lat counts posedges after the accepting edge; sampling happens on negedges.
    task automatic wait_ready(input int lat0, output int lat_o, output int bcnt_o);
        lat_o  = lat0;
        bcnt_o = 0;
        while (!ready && lat_o < 200) begin
            if (busy) bcnt_o++;
            @(negedge clk);
            lat_o++;
        end
    endtask

    task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat_o, output int bcnt_o);
        @(negedge clk);
        start      = 1'b1;
        signed_div = s;
        opdata1    = a;
        opdata2    = b;
        @(negedge clk);
        start      = 1'b0;
        signed_div = ~s;
        opdata1    = ~a;
        opdata2    = ~b;
        wait_ready(0, lat_o, bcnt_o);
    endtask

    initial begin
        #3;
        check("rst_busy",     64'(busy),     64'd0);
        check("rst_ready",    64'(ready),    64'd0);
        check("rst_div_zero", 64'(div_zero), 64'd0);
        check("rst_result",   result,        64'd0);
        @(negedge clk);
        resetn = 1'b1;

        // DIVU 100/7
        run_op(1'b0, 32'd100, 32'd7, lat, bcnt);
        check("divu_lat",    64'(lat),      64'd33);
        check("divu_busy",   64'(bcnt),     64'd33);
        check("divu_result", result,        {32'd2, 32'd14});
        check("divu_dz",     64'(div_zero), 64'd0);
        @(negedge clk);
        check("divu_ready_pulse", 64'(ready), 64'd0);
        check("divu_hold",        result,     {32'd2, 32'd14});

        // Signed sign rules
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
        check("div_m7_2_lat", 64'(lat), 64'd33);
        check("div_m7_2",     result,   {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, lat, bcnt);
        check("div_7_m2",     result,   {32'd1, 32'hFFFF_FFFD});

        // Most-negative / -1, then the same bits unsigned
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        check("div_min_m1",  result, {32'd0, 32'h8000_0000});
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        check("divu_min_m1", result, {32'h8000_0000, 32'd0});

        // Divide by zero
        run_op(1'b0, 32'd5, 32'd0, lat, bcnt);
        check("dz_lat",    64'(lat),      64'd2);
        check("dz_busy",   64'(bcnt),     64'd2);
        check("dz_flag",   64'(div_zero), 64'd1);
        check("dz_result", result,        64'd0);
        @(negedge clk);
        check("dz_ready_pulse", 64'(ready), 64'd0);

        run_op(1'b0, 32'd100, 32'd7, lat, bcnt);
        check("re_result", result,        {32'd2, 32'd14});
        check("re_dz",     64'(div_zero), 64'd0);

        // start and annul together in IDLE: nothing starts
        @(negedge clk);
        start = 1'b1; annul = 1'b1; signed_div = 1'b0; opdata1 = 32'd9; opdata2 = 32'd3;
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        check("annul_idle_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("annul_idle_busy2", 64'(busy), 64'd0);

        // annul at RUN cycle 10
        start = 1'b1; signed_div = 1'b1; opdata1 = 32'd1000; opdata2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("annul_run_busy_before", 64'(busy), 64'd1);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        check("annul_busy",   64'(busy),  64'd0);
        check("annul_ready",  64'(ready), 64'd0);
        check("annul_result", result,     {32'd2, 32'd14});
        run_op(1'b0, 32'hFFFF_FFFF, 32'h10, lat, bcnt);
        check("after_annul_lat",    64'(lat), 64'd33);
        check("after_annul_result", result,   {32'hF, 32'h0FFF_FFFF});

        // start while busy is ignored; operands captured at start
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
        @(negedge clk);
        start = 1'b0; opdata1 = 32'd1; opdata2 = 32'd1;
        repeat (5) @(negedge clk);
        start = 1'b1; signed_div = 1'b1; opdata1 = 32'd50; opdata2 = 32'd5;
        @(negedge clk);
        start = 1'b0;
        wait_ready(6, lat, bcnt);
        check("busy_start_lat",    64'(lat), 64'd33);
        check("busy_start_result", result,   {32'd2, 32'd14});
        repeat (2) @(negedge clk);
        check("busy_start_noqueue", 64'(busy), 64'd0);

        // resetn mid-RUN clears outputs asynchronously
        start = 1'b1; signed_div = 1'b1; opdata1 = 32'hFFFF_FFF9; opdata2 = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("arst_busy",   64'(busy),     64'd0);
        check("arst_ready",  64'(ready),    64'd0);
        check("arst_dz",     64'(div_zero), 64'd0);
        check("arst_result", result,        64'd0);
        @(negedge clk);
        resetn = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready || busy) seen++;
        end
        check("arst_quiet", 64'(seen), 64'd0);

        // div_zero cleared by reset while idle
        run_op(1'b1, 32'd9, 32'd0, lat, bcnt);
        check("dz2_flag", 64'(div_zero), 64'd1);
        #2 resetn = 1'b0;
        #1;
        check("arst_idle_dz", 64'(div_zero), 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, lat, bcnt);
        check("recover_lat",    64'(lat), 64'd33);
        check("recover_result", result,   {32'd1, 32'hFFFF_FFFD});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
